ps2_kbd_tx: RTL and testbench

//  Device-side PS/2 keyboard transmitter; the sending end of the ps2_kbd_clk/ps2_kbd_data pair read by the motherboard.

---
 rtl/ps2_kbd_tx.sv | 207 ++++++++++++++++++++
 tb/tb_ps2_kbd_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: device-side PS/2 keyboard transmitter, 16-byte scancode FIFO feeding 11-bit frames.
// Optional host-inhibit support is enabled with `define PS2_INHIBIT_EN (adds the ps2_clk_in readback).
//
// state  | meaning
// IDLE   | lines idle high, waiting for a queued byte or a pending resend
// BIT_HI | ps2_clk high phase, current frame bit held on ps2_data
// BIT_LO | ps2_clk low phase, receiver samples on the falling edge
// GAP    | both lines high after a frame or an aborted frame
module ps2_kbd_tx #(
   parameter logic [15:0] CLK_DIV = 16'd1000,
   parameter logic [15:0] GAP     = 16'd2000,
   parameter int          FIFO_AW = 4
) (
   input  logic               clk_sys,
   input  logic               RESET_n,
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               busy,
`ifdef PS2_INHIBIT_EN
   input  logic               ps2_clk_in,
`endif
   output logic               ps2_clk,
   output logic               ps2_data
);

   typedef enum logic [1:0] {S_IDLE, S_BIT_HI, S_BIT_LO, S_GAP} state_t;

   localparam int                 DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   FULL  = {1'b1, {FIFO_AW{1'b0}}};

   logic rst_meta_n, rst_sync_n;

   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         rst_meta_n <= 1'b0;
         rst_sync_n <= 1'b0;
      end else begin
         rst_meta_n <= 1'b1;
         rst_sync_n <= rst_meta_n;
      end
   end

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   level;
   logic               push, pop;
   logic [7:0]         head;

   assign in_ready   = (level != FULL);
   assign push       = in_valid && in_ready;
   assign head       = mem[rd_ptr];
   assign fifo_level = level;

   always_ff @(posedge clk_sys) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk_sys or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (FIFO_AW)'(1);
         if (pop)  rd_ptr <= rd_ptr + (FIFO_AW)'(1);
         case ({push, pop})
            2'b10:   level <= level + (FIFO_AW+1)'(1);
            2'b01:   level <= level - (FIFO_AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

   state_t      state, state_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic [3:0]  idx, idx_nxt;
   logic [10:0] frame_q, frame_nxt;
   logic        ps2_clk_q, clk_nxt;
   logic        ps2_data_q, data_nxt;
   logic        retry, retry_nxt;
   logic        inhibited;

`ifdef PS2_INHIBIT_EN
   logic       clk_in_meta, clk_in_sync;
   logic [1:0] hi_age;

   // The readback lags our own clock through the synchroniser, so it is only
   // trusted once ps2_clk has been driven high for two full cycles.
   always_ff @(posedge clk_sys or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         clk_in_meta <= 1'b1;
         clk_in_sync <= 1'b1;
         hi_age      <= 2'd0;
      end else begin
         clk_in_meta <= ps2_clk_in;
         clk_in_sync <= clk_in_meta;
         if (!ps2_clk_q)
            hi_age <= 2'd0;
         else if (hi_age != 2'd2)
            hi_age <= hi_age + 2'd1;
      end
   end

   assign inhibited = (hi_age == 2'd2) && !clk_in_sync;
`else
   assign inhibited = 1'b0;
`endif

   always_ff @(posedge clk_sys or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         idx        <= '0;
         frame_q    <= '1;
         ps2_clk_q  <= 1'b1;
         ps2_data_q <= 1'b1;
         retry      <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         idx        <= idx_nxt;
         frame_q    <= frame_nxt;
         ps2_clk_q  <= clk_nxt;
         ps2_data_q <= data_nxt;
         retry      <= retry_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      frame_nxt = frame_q;
      clk_nxt   = ps2_clk_q;
      data_nxt  = ps2_data_q;
      retry_nxt = retry;
      pop       = 1'b0;
      case (state)
         S_IDLE: begin
            clk_nxt  = 1'b1;
            data_nxt = 1'b1;
            if (!inhibited && (retry || level != '0)) begin
               // A pending resend reuses the held frame instead of popping.
               if (!retry) begin
                  pop       = 1'b1;
                  frame_nxt = {1'b1, ~^head, head, 1'b0};
               end
               retry_nxt = 1'b0;
               idx_nxt   = 4'd0;
               data_nxt  = 1'b0;
               cnt_nxt   = CLK_DIV - 16'd1;
               state_nxt = S_BIT_HI;
            end
         end
         S_BIT_HI: begin
            if (inhibited && idx <= 4'd9) begin
               clk_nxt   = 1'b1;
               data_nxt  = 1'b1;
               retry_nxt = 1'b1;
               cnt_nxt   = GAP - 16'd1;
               state_nxt = S_GAP;
            end else if (cnt == 16'd0) begin
               clk_nxt   = 1'b0;
               cnt_nxt   = CLK_DIV - 16'd1;
               state_nxt = S_BIT_LO;
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         S_BIT_LO: begin
            if (cnt == 16'd0) begin
               clk_nxt = 1'b1;
               if (idx < 4'd10) begin
                  idx_nxt   = idx + 4'd1;
                  data_nxt  = frame_q[idx + 4'd1];
                  cnt_nxt   = CLK_DIV - 16'd1;
                  state_nxt = S_BIT_HI;
               end else begin
                  data_nxt  = 1'b1;
                  cnt_nxt   = GAP - 16'd1;
                  state_nxt = S_GAP;
               end
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         S_GAP: begin
            clk_nxt  = 1'b1;
            data_nxt = 1'b1;
            if (inhibited)
               cnt_nxt = GAP - 16'd1;
            else if (cnt == 16'd0)
               state_nxt = S_IDLE;
            else
               cnt_nxt = cnt - 16'd1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy     = (state != S_IDLE);
   assign ps2_clk  = ps2_clk_q;
   assign ps2_data = ps2_data_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb_ps2_kbd_tx: directed bench for ps2_kbd_tx with a falling-edge frame decoder.
// Inhibit scenarios are compiled in when PS2_INHIBIT_EN is defined.
module tb_ps2_kbd_tx;

   localparam logic [15:0] CLK_DIV = 16'd4;
   localparam logic [15:0] GAP     = 16'd10;
   localparam int          FIFO_AW = 4;

   logic             clk_sys = 1'b0;
   logic             RESET_n;
   logic [7:0]       in_data;
   logic             in_valid;
   logic             in_ready;
   logic [FIFO_AW:0] fifo_level;
   logic             busy;
   logic             ps2_clk;
   logic             ps2_data;
`ifdef PS2_INHIBIT_EN
   logic             host_inh = 1'b0;
   logic             ps2_clk_in;
   assign ps2_clk_in = ps2_clk & ~host_inh;
`endif

   ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .GAP(GAP), .FIFO_AW(FIFO_AW)) dut (
      .clk_sys    (clk_sys),
      .RESET_n    (RESET_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .fifo_level (fifo_level),
      .busy       (busy),
`ifdef PS2_INHIBIT_EN
      .ps2_clk_in (ps2_clk_in),
`endif
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data)
   );

   always #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Decoder: one bit per ps2_clk falling edge; a long quiet spell starts a new frame.
   logic        prev_clk = 1'b1;
   int          nbit = 0;
   int          last_fall = 0;
   logic [10:0] sh = '0;
   logic [10:0] rx_q[$];

   always @(negedge clk_sys) begin
      prev_clk <= ps2_clk;
      if (!RESET_n) begin
         nbit <= 0;
      end else if (prev_clk && !ps2_clk) begin
         if (nbit == 0 || cyc - last_fall > 4 * CLK_DIV) begin
            sh[0] <= ps2_data;
            nbit  <= 1;
         end else begin
            check("fall_spacing", cyc - last_fall, 2 * CLK_DIV);
            sh[nbit] <= ps2_data;
            if (nbit == 10) begin
               rx_q.push_back({ps2_data, sh[9:0]});
               nbit <= 0;
            end else begin
               nbit <= nbit + 1;
            end
         end
         last_fall <= cyc;
      end
   end

   task automatic push(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk_sys);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int b = 0;
      while (busy && b < 2000) begin
         @(negedge clk_sys);
         b++;
      end
      check("idle_wait", busy, 1'b0);
   endtask

   task automatic wait_rx(input int n);
      int b = 0;
      while (rx_q.size() < n && b < 5000) begin
         @(negedge clk_sys);
         b++;
      end
      check("rx_count", rx_q.size(), n);
   endtask

   task automatic wait_line(input bit sel_clk, input logic val, output int at);
      int b = 0;
      while (((sel_clk ? ps2_clk : ps2_data) !== val) && b < 5000) begin
         @(negedge clk_sys);
         b++;
      end
      check(sel_clk ? "clk_wait" : "data_wait", sel_clk ? ps2_clk : ps2_data, val);
      at = cyc;
   endtask

   task automatic check_frame(input logic [10:0] f, input logic [7:0] b);
      check("frame_start",  f[0], 1'b0);
      check("frame_data",   f[8:1], b);
      check("frame_parity", $countones(f[9:1]) & 1, 1);
      check("frame_stop",   f[10], 1'b1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s, r, s2, t, b;
      logic [10:0] f;
      RESET_n  = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #1 RESET_n = 1'b0;
      repeat (3) @(negedge clk_sys);
      check("rst_clk",   ps2_clk, 1'b1);
      check("rst_data",  ps2_data, 1'b1);
      check("rst_busy",  busy, 1'b0);
      check("rst_level", fifo_level, 0);
      check("rst_ready", in_ready, 1'b1);
      RESET_n = 1'b1;
      repeat (5) @(negedge clk_sys);

      // Single byte 0x1C: latency, bit pattern, frame length.
      push(8'h1C);
      check("lat_busy0",  busy, 1'b0);
      check("lat_data1",  ps2_data, 1'b1);
      check("lat_level1", fifo_level, 1);
      @(negedge clk_sys);
      check("start_busy",  busy, 1'b1);
      check("start_data",  ps2_data, 1'b0);
      check("start_clk",   ps2_clk, 1'b1);
      check("start_level", fifo_level, 0);
      s = cyc;
      wait_rx(1);
      f = rx_q.pop_front();
      check("frame_1c", f, 11'h438);
      wait_line(1'b1, 1'b1, r);
      check("frame_len", r - s, 22 * CLK_DIV);
      check("gap_busy", busy, 1'b1);
      wait_idle();

      // Back-to-back 0xF0, 0x1C: parity 1 then 0, GAP+1 idle cycles between.
      push(8'hF0);
      push(8'h1C);
      wait_line(1'b0, 1'b0, s);
      wait_rx(1);
      wait_line(1'b1, 1'b1, r);
      check("b2b_len", r - s, 22 * CLK_DIV);
      wait_line(1'b0, 1'b0, s2);
      check("b2b_gap", s2 - r, GAP + 1);
      wait_rx(2);
      f = rx_q.pop_front();
      check("frame_f0", f, 11'h7E0);
      f = rx_q.pop_front();
      check("frame_1c_b", f, 11'h438);
      wait_idle();

      // Fill FIFO, overflow write dropped, push+pop at level 5.
      for (int i = 0; i < 17; i++) push(8'h30 + 8'(i));
      check("full_level", fifo_level, 16);
      check("full_ready", in_ready, 1'b0);
      push(8'hAA);
      check("ovf_level", fifo_level, 16);
      check("ovf_ready", in_ready, 1'b0);
      b = 0;
      while (!(fifo_level == 5 && !busy) && b < 3000) begin
         @(negedge clk_sys);
         b++;
      end
      check("lvl5_idle", (fifo_level == 5) && !busy, 1'b1);
      push(8'h77);
      check("pushpop_level", fifo_level, 5);
      check("pushpop_busy",  busy, 1'b1);
      wait_rx(18);
      for (int i = 0; i < 17; i++) check_frame(rx_q[i], 8'h30 + 8'(i));
      check_frame(rx_q[17], 8'h77);
      wait_idle();
      repeat (50) @(negedge clk_sys);
      check("no_aa_sent", rx_q.size(), 18);
      check("drained", fifo_level, 0);
      rx_q.delete();

`ifdef PS2_INHIBIT_EN
      // Inhibit at data bit 4: abort, hold lines high, resend whole frame.
      push(8'h1C);
      b = 0;
      while (!(nbit == 5 && ps2_clk) && b < 500) begin
         @(negedge clk_sys);
         b++;
      end
      host_inh = 1'b1;
      repeat (6) @(negedge clk_sys);
      check("inh_clk",  ps2_clk, 1'b1);
      check("inh_data", ps2_data, 1'b1);
      check("inh_busy", busy, 1'b1);
      repeat (30) @(negedge clk_sys);
      check("inh_hold_data", ps2_data, 1'b1);
      check("inh_no_frame", rx_q.size(), 0);
      host_inh = 1'b0;
      t = cyc;
      wait_line(1'b0, 1'b0, s);
      check("resend_after_gap", (s - t) >= GAP, 1'b1);
      wait_rx(1);
      check("resend_frame", rx_q[0], 11'h438);
      repeat (300) @(negedge clk_sys);
      check("resend_once", rx_q.size(), 1);
      rx_q.delete();

      // Inhibit during stop bit: frame completes, no resend.
      push(8'h1C);
      b = 0;
      while (!(nbit == 10 && ps2_clk) && b < 500) begin
         @(negedge clk_sys);
         b++;
      end
      host_inh = 1'b1;
      wait_rx(1);
      check("stop_inh_frame", rx_q[0], 11'h438);
      repeat (20) @(negedge clk_sys);
      host_inh = 1'b0;
      repeat (300) @(negedge clk_sys);
      check("stop_inh_once", rx_q.size(), 1);
      check("stop_inh_idle", busy, 1'b0);
      rx_q.delete();
`endif

      // Reset mid-frame with bytes queued.
      push(8'h55);
      push(8'h66);
      push(8'h77);
      wait_line(1'b1, 1'b0, t);
      #2 RESET_n = 1'b0;
      #1;
      check("midrst_clk",   ps2_clk, 1'b1);
      check("midrst_data",  ps2_data, 1'b1);
      check("midrst_busy",  busy, 1'b0);
      check("midrst_level", fifo_level, 0);
      check("midrst_ready", in_ready, 1'b1);
      repeat (3) @(negedge clk_sys);
      RESET_n = 1'b1;
      repeat (200) @(negedge clk_sys);
      check("midrst_no_frame", rx_q.size(), 0);
      check("midrst_idle",     busy, 1'b0);
      check("midrst_line",     ps2_data, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
